rgb2gray_frame_sequencer: RTL and testbench
===========================================

// Module: rgb2gray_frame_sequencer
// PURPOSE
//  Sequences the rgb2gray datapath over a whole frame. Fetches packed RGB bytes from a source
//  buffer via an Avalon-MM master and drives the datapath clear/load strobes. Writes each gray
//  result byte to a destination buffer. Sits between the system interconnect and one
//  rgb2gray datapath instance, replacing per-pixel software handshaking.
// PARAMETERS
//  ADDR_W  32  Avalon byte-address width
//  CNT_W   16  pixel-count width (max frame = 2^CNT_W-1 pixels)
// PORTS
//  clk_i             in   1       clock, all logic on rising edge
//  rst_i             in   1       asynchronous, active-low reset
//  start_i           in   1       start request, sampled in IDLE only
//  src_base_i        in   ADDR_W  byte address of first R byte (R,G,B consecutive per pixel)
//  dst_base_i        in   ADDR_W  byte address of first gray byte
//  pix_count_i       in   CNT_W   number of pixels to process
//  busy_o            out  1       high in every state except IDLE
//  done_o            out  1       one-cycle pulse at frame completion
//  avm_address_o     out  ADDR_W  Avalon address
//  avm_read_o        out  1       Avalon read strobe
//  avm_write_o       out  1       Avalon write strobe
//  avm_writedata_o   out  8       gray byte to store
//  avm_readdata_i    in   8       read data, valid in cycle read accepted
//  avm_waitrequest_i in   1       slave stall; transfer accepted when strobe=1 and waitrequest=0
//  dp_clear_o        out  1       clears datapath accumulator
//  dp_ld_o           out  1       datapath loads dp_data_o (R, G, B order)
//  dp_data_o         out  8       colour byte to datapath (= avm_readdata_i)
//  dp_gray_i         in   8       datapath result, valid one cycle after third dp_ld_o
// BEHAVIOUR
//  Reset: state IDLE.
//   - All outputs 0: busy, done, avm strobes, address, writedata, dp strobes.
//   - Pointers and counters cleared.
//   - Mid-operation reset aborts silently; no transfer is resumed.
//  States:
//   - IDLE:   start_i=1 -> latch src/dst/count into src_ptr, dst_ptr, remaining.
//             remaining==0 -> DONE, else CLEAR. start_i ignored outside IDLE.
//   - CLEAR:  dp_clear_o=1 for exactly one cycle -> RD_R.
//   - RD_R/RD_G/RD_B: avm_read_o=1, avm_address_o=src_ptr; strobe/address held while waitrequest=1.
//             On accept: dp_ld_o=1 in the same cycle, src_ptr+=1, advance to next state.
//             RD_B advances to SETTLE.
//   - SETTLE: one idle cycle for datapath result -> WR.
//   - WR:     avm_write_o=1, avm_address_o=dst_ptr, avm_writedata_o=dp_gray_i.
//             Write data is registered on WR entry and held stable across stalls.
//             On accept: dst_ptr+=1, remaining-=1; remaining now 0 -> DONE, else CLEAR.
//   - DONE:   done_o=1 for one cycle -> IDLE.
//  Invariants:
//   - Never read and write in the same cycle.
//   - dp_ld_o only in an accepted read cycle.
//   - dp_data_o is a combinational pass of avm_readdata_i; downstream uses it only with dp_ld_o.
//  Timing:
//   - Zero wait states: 6 cycles per pixel (CLEAR,RD_R,RD_G,RD_B,SETTLE,WR).
//   - busy_o high for 6*N+1 cycles, starting the cycle after start_i is sampled.
//   - Each waitrequest cycle adds exactly one cycle.
//  Arithmetic: pointers wrap modulo 2^ADDR_W, no error flag; remaining never underflows.
//  start_i held high across DONE->IDLE re-launches on the first IDLE cycle (back-to-back frames).
// TESTING
//  - Reset values: rst_i=0 mid-RD_G -> next edge all outputs 0, state IDLE; release, start -> fresh frame.
//  - Zero pixels: pix_count=0, start -> done_o pulse 2nd cycle.
//    busy high 1 cycle; no avm_read_o/avm_write_o ever.
//  - Single pixel: src=0x100, RGB=(0x30,0x60,0x90), model gray=G, dst=0x200, no stalls.
//    -> reads 0x100/0x101/0x102, three dp_ld_o pulses, write G to 0x200, done at cycle 7.
//  - Stalls: waitrequest=1 for 3 cycles on RD_G and 2 on WR.
//    -> address/strobe/writedata stable throughout, one dp_ld per byte, total +5 cycles.
//  - Frame of 4 pixels: src=0x0, dst=0x40.
//    -> reads 0x0..0xB in order, writes 0x40..0x43, 4 clear pulses, done once, busy 25 cycles.
//  - start_i asserted while busy (and continuously held) -> ignored mid-frame.
//    Second frame starts immediately after done with freshly latched inputs.

Source files
------------

// File: rtl/rgb2gray_frame_sequencer.sv
// rtl/rgb2gray_frame_sequencer.sv - frame-level Avalon-MM sequencer for the rgb2gray datapath
module rgb2gray_frame_sequencer #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_base_i,
   input  logic [ADDR_W-1:0] dst_base_i,
   input  logic [CNT_W-1:0]  pix_count_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] avm_address_o,
   output logic              avm_read_o,
   output logic              avm_write_o,
   output logic [7:0]        avm_writedata_o,
   input  logic [7:0]        avm_readdata_i,
   input  logic              avm_waitrequest_i,
   output logic              dp_clear_o,
   output logic              dp_ld_o,
   output logic [7:0]        dp_data_o,
   input  logic [7:0]        dp_gray_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_RD_R   = 3'd2;
   localparam logic [2:0] S_RD_G   = 3'd3;
   localparam logic [2:0] S_RD_B   = 3'd4;
   localparam logic [2:0] S_SETTLE = 3'd5;
   localparam logic [2:0] S_WR     = 3'd6;
   localparam logic [2:0] S_DONE   = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
   logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              rd_state;

   assign rd_state = (state_q == S_RD_R) || (state_q == S_RD_G) || (state_q == S_RD_B);

   // Next-state and pointer/counter updates; reads advance only on an accepted transfer
   always_comb begin
      state_d     = state_q;
      src_ptr_d   = src_ptr_q;
      dst_ptr_d   = dst_ptr_q;
      remaining_d = remaining_q;
      wdata_d     = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               src_ptr_d   = src_base_i;
               dst_ptr_d   = dst_base_i;
               remaining_d = pix_count_i;
               state_d     = (pix_count_i == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: state_d = S_RD_R;
         S_RD_R, S_RD_G, S_RD_B: begin
            if (!avm_waitrequest_i) begin
               src_ptr_d = src_ptr_q + ADDR_W'(1);
               case (state_q)
                  S_RD_R:  state_d = S_RD_G;
                  S_RD_G:  state_d = S_RD_B;
                  default: state_d = S_SETTLE;
               endcase
            end
         end
         S_SETTLE: begin
            // Datapath result is valid here; hold it so the write data stays stable across stalls
            wdata_d = dp_gray_i;
            state_d = S_WR;
         end
         S_WR: begin
            if (!avm_waitrequest_i) begin
               dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
               remaining_d = (remaining_q != '0) ? remaining_q - CNT_W'(1) : remaining_q;
               state_d     = (remaining_q <= CNT_W'(1)) ? S_DONE : S_CLEAR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         remaining_q <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         src_ptr_q   <= src_ptr_d;
         dst_ptr_q   <= dst_ptr_d;
         remaining_q <= remaining_d;
         wdata_q     <= wdata_d;
      end
   end

   // Outputs decoded from state; dp_ld_o marks the accepted read cycle only
   always_comb begin
      busy_o          = (state_q != S_IDLE);
      done_o          = (state_q == S_DONE);
      avm_read_o      = rd_state;
      avm_write_o     = (state_q == S_WR);
      avm_address_o   = '0;
      if (rd_state) begin
         avm_address_o = src_ptr_q;
      end else if (state_q == S_WR) begin
         avm_address_o = dst_ptr_q;
      end
      avm_writedata_o = wdata_q;
      dp_clear_o      = (state_q == S_CLEAR);
      dp_ld_o         = rd_state && !avm_waitrequest_i;
      dp_data_o       = avm_readdata_i;
   end

endmodule

// File: tb/tb_rgb2gray_frame_sequencer.sv
// tb/tb_rgb2gray_frame_sequencer.sv - directed vector bench for rgb2gray_frame_sequencer
module tb_rgb2gray_frame_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_base, dst_base;
   logic [15:0] pix_count;
   logic        busy, done;
   logic [31:0] avm_address;
   logic        avm_read, avm_write;
   logic [7:0]  avm_wd, avm_rdata;
   logic        waitreq;
   logic        dp_clear, dp_ld;
   logic [7:0]  dp_data, dp_gray;

   logic [7:0]  mem [256];
   logic [1:0]  dp_idx = 2'd0;
   logic [7:0]  dp_g   = 8'd0;
   logic [7:0]  dp_res = 8'd0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] cnt;
      int          sg;
      int          sw;
      int          exp_busy;
   } vec_t;

   vec_t vecs[5];

   rgb2gray_frame_sequencer #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_i           (start),
      .src_base_i        (src_base),
      .dst_base_i        (dst_base),
      .pix_count_i       (pix_count),
      .busy_o            (busy),
      .done_o            (done),
      .avm_address_o     (avm_address),
      .avm_read_o        (avm_read),
      .avm_write_o       (avm_write),
      .avm_writedata_o   (avm_wd),
      .avm_readdata_i    (avm_rdata),
      .avm_waitrequest_i (waitreq),
      .dp_clear_o        (dp_clear),
      .dp_ld_o           (dp_ld),
      .dp_data_o         (dp_data),
      .dp_gray_i         (dp_gray)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign avm_rdata = mem[avm_address[7:0]];
   assign dp_gray   = dp_res;

   // Datapath model: gray = G, published one cycle after the third load
   always @(posedge clk) begin
      if (dp_clear) begin
         dp_idx <= 2'd0;
      end else if (dp_ld) begin
         if (dp_idx == 2'd1) dp_g <= dp_data;
         if (dp_idx == 2'd2) dp_res <= dp_g;
         dp_idx <= dp_idx + 2'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_frame(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt,
                            input int sg, input int sw, input int exp_busy,
                            input bit launch, input bit hold,
                            input logic [31:0] nsrc, input logic [31:0] ndst, input logic [15:0] ncnt);
      int busy_n, done_n, done_cyc, rd_n, wr_n, clr_n, ld_n, sgc, swc;
      bit prev_stall, ended;
      logic [31:0] p_addr, ea;
      logic        p_rd, p_wr;
      logic [7:0]  p_wd;
      busy_n = 0; done_n = 0; done_cyc = -1; rd_n = 0; wr_n = 0; clr_n = 0; ld_n = 0;
      sgc = 0; swc = 0; prev_stall = 0; ended = 0;
      p_addr = '0; p_rd = 0; p_wr = 0; p_wd = '0;
      if (launch) begin
         @(negedge clk);
         src_base = src; dst_base = dst; pix_count = cnt; start = 1'b1;
      end
      @(negedge clk);
      start = hold; src_base = nsrc; dst_base = ndst; pix_count = ncnt;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         waitreq = 1'b0;
         if (avm_read && rd_n == 1 && sgc < sg) begin waitreq = 1'b1; sgc++; end
         if (avm_write && wr_n == 0 && swc < sw) begin waitreq = 1'b1; swc++; end
         #1;
         if (!busy) begin ended = 1; break; end
         busy_n++;
         if (done) begin done_n++; done_cyc = cyc; end
         if (dp_clear) clr_n++;
         if (dp_ld) ld_n++;
         chk("rw_exclusive", {31'd0, avm_read & avm_write}, 32'd0);
         chk("ld_only_on_accept", {31'd0, dp_ld}, {31'd0, avm_read & ~waitreq});
         if (prev_stall) begin
            chk("stall_addr", avm_address, p_addr);
            chk("stall_read", {31'd0, avm_read}, {31'd0, p_rd});
            chk("stall_write", {31'd0, avm_write}, {31'd0, p_wr});
            chk("stall_wdata", {24'd0, avm_wd}, {24'd0, p_wd});
         end
         if (avm_read && !waitreq) begin
            ea = src + rd_n;
            chk("rd_addr", avm_address, ea);
            chk("dp_data", {24'd0, dp_data}, {24'd0, mem[ea[7:0]]});
            rd_n++;
         end
         if (avm_write && !waitreq) begin
            ea = dst + wr_n;
            chk("wr_addr", avm_address, ea);
            ea = src + 3 * wr_n + 1;
            chk("wr_data", {24'd0, avm_wd}, {24'd0, mem[ea[7:0]]});
            wr_n++;
         end
         prev_stall = (avm_read | avm_write) & waitreq;
         p_addr = avm_address; p_rd = avm_read; p_wr = avm_write; p_wd = avm_wd;
         @(negedge clk);
      end
      waitreq = 1'b0;
      if (!ended) begin
         total++; bad++;
         $display("FAIL frame_timeout: busy never dropped for src=%h cnt=%0d", src, cnt);
      end
      chk("busy_cycles", busy_n, exp_busy);
      chk("done_pulses", done_n, 1);
      chk("done_cycle", done_cyc, exp_busy);
      chk("read_count", rd_n, 3 * cnt);
      chk("write_count", wr_n, cnt);
      chk("clear_count", clr_n, cnt);
      chk("ld_count", ld_n, 3 * cnt);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
      mem[0] = 8'h30; mem[1] = 8'h60; mem[2] = 8'h90;

      vecs[0] = '{32'h100,      32'h200,      16'd1, 0, 0, 7};
      vecs[1] = '{32'h100,      32'h200,      16'd1, 3, 2, 12};
      vecs[2] = '{32'h0,        32'h40,       16'd4, 0, 0, 25};
      vecs[3] = '{32'h10,       32'h80,       16'd0, 0, 0, 1};
      vecs[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 16'd2, 0, 0, 13};

      rst = 1'b0; start = 1'b0; waitreq = 1'b0;
      src_base = '0; dst_base = '0; pix_count = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_strobes", {29'd0, avm_read, avm_write, dp_clear}, 32'd0);
      chk("reset_addr", avm_address, 32'd0);
      chk("reset_wdata", {24'd0, avm_wd}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].sg, vecs[v].sw, vecs[v].exp_busy,
                   1'b1, 1'b0, vecs[v].src, vecs[v].dst, vecs[v].cnt);
      end

      // start held high through the whole first frame; new inputs presented mid-frame
      run_frame(32'h0, 32'h40, 16'd1, 0, 0, 7, 1'b1, 1'b1, 32'h20, 32'h90, 16'd2);
      run_frame(32'h20, 32'h90, 16'd2, 0, 0, 13, 1'b0, 1'b0, 32'h20, 32'h90, 16'd2);

      // reset asserted while the G byte read is pending
      @(negedge clk);
      src_base = 32'h0; dst_base = 32'h40; pix_count = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("pre_reset_rd_g_addr", avm_address, 32'h1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_done", {31'd0, done}, 32'd0);
      chk("midreset_strobes", {27'd0, avm_read, avm_write, dp_clear, dp_ld, 1'b0}, 32'd0);
      chk("midreset_addr", avm_address, 32'd0);
      chk("midreset_wdata", {24'd0, avm_wd}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_frame(32'h3, 32'h50, 16'd2, 0, 0, 13, 1'b1, 1'b0, 32'h3, 32'h50, 16'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
